// File: rtl/systolic_host_if.sv
`default_nettype none
// ============================================================================
// Module   : systolic_host_if
// Purpose  : Byte-wide host interface for an NxN systolic matmul core.
//            Optional watchdog: define SYSTOLIC_HOST_IF_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module systolic_host_if #(
    parameter int N       = 4,
    parameter int A_W     = 16,
    parameter int B_W     = 8,
    parameter int R_W     = 32,
    parameter int AW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           data_in,
    output logic [7:0]           data_out,
    input  logic [AW-1:0]        addr,
    input  logic                 write_en,
    input  logic                 read_en,
    input  logic                 start,
    output logic                 ready,
    output logic                 done,
    output logic                 core_start,
    output logic [N*N*A_W-1:0]   core_a,
    output logic [N*N*B_W-1:0]   core_b,
    input  logic [N*N*R_W-1:0]   core_result,
    input  logic                 core_result_valid
);

    localparam int c_a_bytes = N * N * A_W / 8;
    localparam int c_b_bytes = N * N * B_W / 8;
    localparam int c_r_bytes = N * N * R_W / 8;
    localparam int c_r_end_i = c_a_bytes + c_b_bytes + c_r_bytes;
    localparam int c_a_iw    = (c_a_bytes > 1) ? $clog2(c_a_bytes) : 1;
    localparam int c_b_iw    = (c_b_bytes > 1) ? $clog2(c_b_bytes) : 1;
    localparam int c_r_iw    = (c_r_bytes > 1) ? $clog2(c_r_bytes) : 1;

    localparam logic [AW-1:0] c_b_base      = AW'(c_a_bytes);
    localparam logic [AW-1:0] c_r_base      = AW'(c_a_bytes + c_b_bytes);
    localparam logic [AW-1:0] c_r_end       = AW'(c_r_end_i);
    localparam logic [AW-1:0] c_ctrl_addr   = {{(AW-1){1'b1}}, 1'b0};
    localparam logic [AW-1:0] c_status_addr = {AW{1'b1}};

    if (c_r_end_i > (2**AW) - 2) begin : g_map_check
        $error("systolic_host_if: operand/result banks overlap CTRL/STATUS");
    end
    if (TIMEOUT < 1) begin : g_timeout_check
        $error("systolic_host_if: TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_ready;
    logic        r_done;
    logic        r_core_start;
    logic        r_wr_busy_err;
    logic [7:0]  r_data_out;
    logic [7:0]  r_a [c_a_bytes];
    logic [7:0]  r_b [c_b_bytes];
    logic [7:0]  r_r [c_r_bytes];

    logic              w_in_a;
    logic              w_in_b;
    logic              w_in_r;
    logic [c_a_iw-1:0] w_a_idx;
    logic [c_b_iw-1:0] w_b_idx;
    logic [c_r_iw-1:0] w_r_idx;
    logic              w_ctrl_wr;
    logic              w_start;
    logic              w_clear;
    logic              w_busy;
    logic              w_ab_wr;
    logic              w_wd_hit;
    logic              w_timeout_err;
    logic [7:0]        w_status;

    assign w_in_a    = (addr < c_b_base);
    assign w_in_b    = (addr >= c_b_base) && (addr < c_r_base);
    assign w_in_r    = (addr >= c_r_base) && (addr < c_r_end);
    assign w_a_idx   = c_a_iw'(addr);
    assign w_b_idx   = c_b_iw'(addr - c_b_base);
    assign w_r_idx   = c_r_iw'(addr - c_r_base);
    assign w_ctrl_wr = write_en && (addr == c_ctrl_addr);
    assign w_start   = start || (w_ctrl_wr && data_in[0]);
    assign w_clear   = w_ctrl_wr && data_in[1];
    assign w_busy    = (r_state == S_RUN);
    assign w_ab_wr   = write_en && (w_in_a || w_in_b);
    assign w_status  = {3'b000, r_wr_busy_err, w_timeout_err, w_busy, r_done, r_ready};

`ifdef SYSTOLIC_HOST_IF_TIMEOUT_EN
    localparam int c_wd_w = $clog2(TIMEOUT + 1);

    logic [c_wd_w-1:0] r_wd_cnt;
    logic              r_timeout_err;

    // Counter is held at zero outside RUN, so every RUN entry starts from zero.
    assign w_wd_hit      = w_busy && !core_result_valid && (r_wd_cnt == c_wd_w'(TIMEOUT - 1));
    assign w_timeout_err = r_timeout_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_busy) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end else begin
                r_wd_cnt <= '0;
            end
            if (w_clear) begin
                r_timeout_err <= 1'b0;
            end
            if (w_wd_hit) begin
                r_timeout_err <= 1'b1;
            end
        end
    end
`else
    assign w_wd_hit      = 1'b0;
    assign w_timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_ready       <= 1'b1;
            r_done        <= 1'b0;
            r_core_start  <= 1'b0;
            r_wr_busy_err <= 1'b0;
            for (int i = 0; i < c_a_bytes; i++) r_a[i] <= 8'h00;
            for (int i = 0; i < c_b_bytes; i++) r_b[i] <= 8'h00;
            for (int i = 0; i < c_r_bytes; i++) r_r[i] <= 8'h00;
        end else begin
            r_core_start <= 1'b0;
            if (w_clear) begin
                r_wr_busy_err <= 1'b0;
            end
            // Operand writes land even on the launch edge, so the core sees them with core_start.
            if (w_ab_wr) begin
                if (w_busy) begin
                    r_wr_busy_err <= 1'b1;
                end else if (w_in_a) begin
                    r_a[w_a_idx] <= data_in;
                end else begin
                    r_b[w_b_idx] <= data_in;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state      <= S_RUN;
                        r_core_start <= 1'b1;
                        r_ready      <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (core_result_valid) begin
                        for (int i = 0; i < c_r_bytes; i++) r_r[i] <= core_result[i*8 +: 8];
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                    end else if (w_wd_hit) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (w_start) begin
                        r_state      <= S_RUN;
                        r_core_start <= 1'b1;
                        r_ready      <= 1'b0;
                        r_done       <= 1'b0;
                    end else if (w_clear) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out <= 8'h00;
        end else if (!read_en) begin
            r_data_out <= 8'h00;
        end else if (w_in_a) begin
            r_data_out <= r_a[w_a_idx];
        end else if (w_in_b) begin
            r_data_out <= r_b[w_b_idx];
        end else if (w_in_r) begin
            r_data_out <= r_r[w_r_idx];
        end else if (addr == c_status_addr) begin
            r_data_out <= w_status;
        end else begin
            r_data_out <= 8'h00;
        end
    end

    for (genvar i = 0; i < c_a_bytes; i++) begin : g_core_a
        assign core_a[i*8 +: 8] = r_a[i];
    end
    for (genvar i = 0; i < c_b_bytes; i++) begin : g_core_b
        assign core_b[i*8 +: 8] = r_b[i];
    end

    assign data_out   = r_data_out;
    assign ready      = r_ready;
    assign done       = r_done;
    assign core_start = r_core_start;

endmodule
`default_nettype wire

// File: tb/tb_systolic_host_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_host_if
// Purpose  : Directed sequence with random data against a byte-level model.
// Revision : 1.0
// ============================================================================
module tb_systolic_host_if;

    localparam int N       = 4;
    localparam int A_W     = 16;
    localparam int B_W     = 8;
    localparam int R_W     = 32;
    localparam int AW      = 8;
    localparam int TIMEOUT = 255;

    localparam int c_a_bytes = N * N * A_W / 8;
    localparam int c_b_bytes = N * N * B_W / 8;
    localparam int c_r_bytes = N * N * R_W / 8;
    localparam int c_r_base  = c_a_bytes + c_b_bytes;
    localparam int c_ctrl    = 254;
    localparam int c_status  = 255;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [7:0]           data_in = 8'h00;
    logic [7:0]           data_out;
    logic [AW-1:0]        addr = '0;
    logic                 write_en = 1'b0;
    logic                 read_en = 1'b0;
    logic                 start = 1'b0;
    logic                 ready;
    logic                 done;
    logic                 core_start;
    logic [N*N*A_W-1:0]   core_a;
    logic [N*N*B_W-1:0]   core_b;
    logic [N*N*R_W-1:0]   core_result = '0;
    logic                 core_result_valid = 1'b0;

    systolic_host_if #(
        .N(N), .A_W(A_W), .B_W(B_W), .R_W(R_W), .AW(AW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .data_in(data_in),
        .data_out(data_out),
        .addr(addr),
        .write_en(write_en),
        .read_en(read_en),
        .start(start),
        .ready(ready),
        .done(done),
        .core_start(core_start),
        .core_a(core_a),
        .core_b(core_b),
        .core_result(core_result),
        .core_result_valid(core_result_valid)
    );

    always #5 clk = ~clk;

    // Behavioural model: byte banks plus the host-visible flags
    logic [7:0] m_a [c_a_bytes];
    logic [7:0] m_b [c_b_bytes];
    logic [7:0] m_r [c_r_bytes];
    bit m_running, m_done, m_wbe, m_toe;

    int n_checks = 0;
    int n_errors = 0;
    int launches = 0;

    always @(negedge clk) if (core_start) launches++;

    function automatic logic [7:0] m_status();
        return {3'b000, m_wbe, m_toe, m_running, m_done, !m_running};
    endfunction

    function automatic logic [7:0] m_read(input int a);
        if (a < c_a_bytes) return m_a[a];
        if (a < c_r_base) return m_b[a - c_a_bytes];
        if (a < c_r_base + c_r_bytes) return m_r[a - c_r_base];
        if (a == c_status) return m_status();
        return 8'h00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < c_a_bytes; i++) m_a[i] = 8'h00;
        for (int i = 0; i < c_b_bytes; i++) m_b[i] = 8'h00;
        for (int i = 0; i < c_r_bytes; i++) m_r[i] = 8'h00;
        m_running = 0; m_done = 0; m_wbe = 0; m_toe = 0;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Host write; operand bytes follow the bank rules, CTRL effects are modelled by the caller.
    task automatic do_wr(input int a, input logic [7:0] d);
        addr = AW'(a); data_in = d; write_en = 1'b1;
        step();
        write_en = 1'b0;
        if (a < c_r_base) begin
            if (m_running) m_wbe = 1;
            else if (a < c_a_bytes) m_a[a] = d;
            else m_b[a - c_a_bytes] = d;
        end
    endtask

    task automatic rd_chk(input string tag, input int a, input logic [7:0] exp);
        addr = AW'(a); read_en = 1'b1;
        step();
        read_en = 1'b0;
        chk(tag, data_out, exp);
    endtask

    // Core model: presents random results for one cycle, optionally with element 5 fixed.
    task automatic core_reply(input bit force5);
        logic [7:0]  b;
        logic [31:0] e5;
        e5 = 32'h12345678;
        for (int i = 0; i < c_r_bytes; i++) begin
            b = 8'($urandom_range(0, 255));
            m_r[i] = b;
            core_result[i*8 +: 8] = b;
        end
        if (force5) begin
            for (int k = 0; k < 4; k++) begin
                m_r[20 + k] = e5[k*8 +: 8];
                core_result[(20 + k)*8 +: 8] = e5[k*8 +: 8];
            end
        end
        core_result_valid = 1'b1;
        step();
        core_result_valid = 1'b0;
        m_running = 0; m_done = 1;
    endtask

    initial begin
        int a;
        int l0;
        logic [7:0] d;
        logic [N*N*A_W-1:0] ea;
        logic [N*N*B_W-1:0] eb;

        model_reset();
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_core_start", core_start, 0);
        rd_chk("rst_status", c_status, 8'h01);
        rd_chk("rst_a0", 0, 8'h00);
        step();
        chk("rd_low_zero", data_out, 0);

        for (int i = 0; i < c_r_base; i++) do_wr(i, 8'($urandom_range(0, 255)));
        do_wr(8'h0A, 8'hEF);
        do_wr(8'h0B, 8'hBE);
        do_wr(8'h23, 8'h7F);
        do_wr(8'h44, 8'hAA);
        do_wr(c_status, 8'hAA);
        do_wr(8'h90, 8'hAA);
        repeat (8) begin
            a = int'($urandom_range(0, c_r_base - 1));
            rd_chk("rd_ab", a, m_read(a));
        end
        rd_chk("rd_r_write_ignored", 8'h44, 8'h00);
        rd_chk("rd_unmapped", 8'h90, 8'h00);
        rd_chk("rd_ctrl", c_ctrl, 8'h00);
        rd_chk("idle_status", c_status, m_status());
        for (int i = 0; i < c_a_bytes; i++) ea[i*8 +: 8] = m_a[i];
        for (int i = 0; i < c_b_bytes; i++) eb[i*8 +: 8] = m_b[i];
        chk("core_a_vec", core_a, ea);
        chk("core_b_vec", core_b, eb);

        // First launch from the pin
        l0 = launches;
        start = 1'b1; step(); start = 1'b0;
        m_running = 1;
        chk("cs_high", core_start, 1);
        chk("ready_run", ready, 0);
        chk("core_a_e5", core_a[95:80], 16'hBEEF);
        chk("core_b_e3", core_b[31:24], 8'h7F);
        step();
        chk("cs_one_cycle", core_start, 0);

        do_wr(0, 8'h55);
        start = 1'b1; step(); start = 1'b0;
        rd_chk("run_status", c_status, 8'h14);
        rd_chk("run_a0_kept", 0, m_read(0));
        rd_chk("run_r_prev", 8'h44, m_read(8'h44));
        chk("run_no_relaunch", launches, l0 + 1);
        do_wr(c_ctrl, 8'h02);
        m_wbe = 0; m_toe = 0;
        rd_chk("run_clear_status", c_status, m_status());

        // Results arrive together with an ignored start
        repeat (3) step();
        start = 1'b1;
        core_reply(1);
        start = 1'b0;
        chk("cap_done", done, 1);
        chk("cap_ready", ready, 1);
        rd_chk("cap_status", c_status, 8'h03);
        rd_chk("cap_r44", 8'h44, 8'h78);
        rd_chk("cap_r45", 8'h45, 8'h56);
        rd_chk("cap_r46", 8'h46, 8'h34);
        rd_chk("cap_r47", 8'h47, 8'h12);
        repeat (6) begin
            a = int'($urandom_range(c_r_base, c_r_base + c_r_bytes - 1));
            rd_chk("cap_r_rand", a, m_read(a));
        end
        chk("cap_no_relaunch", launches, l0 + 1);

        for (int i = 0; i < c_r_bytes; i++) core_result[i*8 +: 8] = 8'($urandom_range(0, 255));
        repeat (4) begin
            a = int'($urandom_range(c_r_base, c_r_base + c_r_bytes - 1));
            rd_chk("r_hold", a, m_read(a));
        end

        // Relaunch from DONE with an operand write on the same edge
        a = int'($urandom_range(0, c_a_bytes - 1));
        d = 8'($urandom_range(0, 255));
        addr = AW'(a); data_in = d; write_en = 1'b1; start = 1'b1;
        step();
        write_en = 1'b0; start = 1'b0;
        m_a[a] = d; m_running = 1; m_done = 0;
        chk("relaunch_cs", core_start, 1);
        chk("relaunch_core_a_byte", core_a[a*8 +: 8], d);
        chk("relaunch_done_clr", done, 0);
        repeat (3) step();
        core_reply(0);
        rd_chk("run2_status", c_status, m_status());
        repeat (6) begin
            a = int'($urandom_range(c_r_base, c_r_base + c_r_bytes - 1));
            rd_chk("run2_r_rand", a, m_read(a));
        end

        // CTRL clear+start from DONE, then clear to IDLE
        do_wr(c_ctrl, 8'h03);
        m_done = 0; m_wbe = 0; m_toe = 0; m_running = 1;
        chk("ctrl_launch_cs", core_start, 1);
        rd_chk("ctrl_launch_status", c_status, 8'h04);
        core_reply(0);
        do_wr(c_ctrl, 8'h02);
        m_done = 0;
        rd_chk("ctrl_clear_status", c_status, 8'h01);
        chk("ctrl_clear_done", done, 0);

        // Pin and CTRL start together give one launch
        l0 = launches;
        addr = AW'(c_ctrl); data_in = 8'h01; write_en = 1'b1; start = 1'b1;
        step();
        write_en = 1'b0; start = 1'b0;
        m_running = 1;
        chk("dual_start_cs", core_start, 1);
        repeat (2) step();
        chk("dual_start_once", launches, l0 + 1);

`ifdef SYSTOLIC_HOST_IF_TIMEOUT_EN
        repeat (190) step();
        rd_chk("wd_still_busy", c_status, 8'h04);
        repeat (100) step();
        m_running = 0; m_done = 1; m_toe = 1;
        rd_chk("wd_status", c_status, 8'h0B);
        chk("wd_done", done, 1);
        a = int'($urandom_range(c_r_base, c_r_base + c_r_bytes - 1));
        rd_chk("wd_r_kept", a, m_read(a));
        do_wr(c_ctrl, 8'h02);
        m_toe = 0; m_done = 0;
        rd_chk("wd_clear_status", c_status, 8'h01);
`else
        repeat (300) step();
        rd_chk("nowd_status", c_status, 8'h04);
        core_reply(0);
        rd_chk("nowd_done_status", c_status, 8'h03);
        do_wr(c_ctrl, 8'h02);
        m_done = 0;
        rd_chk("nowd_clear_status", c_status, 8'h01);
`endif

        // Reset in the middle of RUN
        start = 1'b1; step(); start = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_cs", core_start, 0);
        step();
        rst_n = 1'b1;
        model_reset();
        step();
        chk("mid_rst_core_a", core_a, 0);
        chk("mid_rst_core_b", core_b, 0);
        for (int i = 0; i < c_r_base + c_r_bytes; i++) rd_chk("mid_rst_bank", i, m_read(i));
        rd_chk("mid_rst_status", c_status, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
